// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, total-period derivation and colour-bar constants for
// the LCD timing driver and its per-axis counters.
package lcd_timing_pkg;

  localparam int CNT_W   = 11;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic int axis_total(input int sync, input int back,
                                    input int disp, input int front);
    return sync + back + disp + front;
  endfunction

  localparam int DEF_H_SYNC  = 128;
  localparam int DEF_H_BACK  = 88;
  localparam int DEF_H_DISP  = 800;
  localparam int DEF_H_FRONT = 40;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_DISP  = 480;
  localparam int DEF_V_FRONT = 10;

  localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_DISP, DEF_H_FRONT);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_DISP, DEF_V_FRONT);

  localparam int NUM_BARS = 8;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// Wrapping counter for one display axis, decoding the sync pulse, the active
// window (optionally led by LEAD counts) and the 1-based position inside it.
module lcd_axis_cnt
  import lcd_timing_pkg::*;
#(
  parameter int SYNC  = DEF_H_SYNC,
  parameter int BACK  = DEF_H_BACK,
  parameter int DISP  = DEF_H_DISP,
  parameter int FRONT = DEF_H_FRONT,
  parameter int LEAD  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             wrap,
  output logic             first,
  output logic             in_sync,
  output logic             in_win,
  output logic [CNT_W-1:0] pos
);

  localparam int               TOTAL    = axis_total(SYNC, BACK, DISP, FRONT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(SYNC + BACK - LEAD);
  localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(SYNC + BACK - LEAD + DISP);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned, which would infer a latch.
    cnt_d   = cnt_q;
    wrap    = en && (cnt_q == LAST);
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    first   = (cnt_q == '0);
    in_sync = (cnt_q < SYNC_END);
    in_win  = (cnt_q >= WIN_LO) && (cnt_q < WIN_HI);
    pos     = in_win ? (cnt_q - WIN_LO + CNT_W'(1)) : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement or process order.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_timing_driver.sv
// Parallel-RGB LCD timing generator with registered sync/enable outputs.
// Optional colour-bar test pattern is built when LCD_TEST_PATTERN_EN is defined.
module lcd_timing_driver
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic             lcd_pclk,
  input  logic             rst,
`ifdef LCD_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  input  logic [23:0]      pixel_data,
  output logic [CNT_W-1:0] pixel_xpos,
  output logic [CNT_W-1:0] pixel_ypos,
  output logic [CNT_W-1:0] h_disp,
  output logic [CNT_W-1:0] v_disp,
  output logic             data_req,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [23:0]      lcd_rgb,
  output logic             frame_start
);

  if (axis_total(H_SYNC, H_BACK, H_DISP, H_FRONT) > CNT_MAX ||
      axis_total(V_SYNC, V_BACK, V_DISP, V_FRONT) > CNT_MAX) begin : g_bad_timing
    $error("lcd_timing_driver: axis total exceeds 11-bit counter range");
  end

  assign h_disp = CNT_W'(H_DISP);
  assign v_disp = CNT_W'(V_DISP);

  logic             h_wrap, h_first, h_in_sync, h_in_win;
  logic             v_wrap_unused, v_first, v_in_sync, v_in_win;
  logic [CNT_W-1:0] h_pos, v_pos;

  // Horizontal window leads by one pixel so coordinates go out a cycle before lcd_de.
  lcd_axis_cnt #(
    .SYNC(H_SYNC), .BACK(H_BACK), .DISP(H_DISP), .FRONT(H_FRONT), .LEAD(1)
  ) u_h_cnt (
    .clk(lcd_pclk), .rst(rst), .en(1'b1),
    .wrap(h_wrap), .first(h_first), .in_sync(h_in_sync), .in_win(h_in_win), .pos(h_pos)
  );

  lcd_axis_cnt #(
    .SYNC(V_SYNC), .BACK(V_BACK), .DISP(V_DISP), .FRONT(V_FRONT), .LEAD(0)
  ) u_v_cnt (
    .clk(lcd_pclk), .rst(rst), .en(h_wrap),
    .wrap(v_wrap_unused), .first(v_first), .in_sync(v_in_sync), .in_win(v_in_win), .pos(v_pos)
  );

  logic             lcd_hs_q, lcd_hs_d;
  logic             lcd_vs_q, lcd_vs_d;
  logic             data_req_q, data_req_d;
  logic             lcd_de_q, lcd_de_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] pixel_xpos_q, pixel_xpos_d;
  logic [CNT_W-1:0] pixel_ypos_q, pixel_ypos_d;

  always_comb begin
    lcd_hs_d      = ~h_in_sync;
    lcd_vs_d      = ~v_in_sync;
    data_req_d    = h_in_win && v_in_win;
    pixel_xpos_d  = data_req_d ? h_pos : '0;
    pixel_ypos_d  = data_req_d ? v_pos : '0;
    lcd_de_d      = data_req_q;
    frame_start_d = h_first && v_first;
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      lcd_hs_q      <= 1'b1;
      lcd_vs_q      <= 1'b1;
      data_req_q    <= 1'b0;
      lcd_de_q      <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_xpos_q  <= '0;
      pixel_ypos_q  <= '0;
    end else begin
      lcd_hs_q      <= lcd_hs_d;
      lcd_vs_q      <= lcd_vs_d;
      data_req_q    <= data_req_d;
      lcd_de_q      <= lcd_de_d;
      frame_start_q <= frame_start_d;
      pixel_xpos_q  <= pixel_xpos_d;
      pixel_ypos_q  <= pixel_ypos_d;
    end
  end

  assign lcd_hs      = lcd_hs_q;
  assign lcd_vs      = lcd_vs_q;
  assign data_req    = data_req_q;
  assign lcd_de      = lcd_de_q;
  assign frame_start = frame_start_q;
  assign pixel_xpos  = pixel_xpos_q;
  assign pixel_ypos  = pixel_ypos_q;

  logic [23:0] rgb_src;

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = H_DISP / NUM_BARS;

  logic [CNT_W-1:0] bar_idx;
  logic [23:0]      bar_q, bar_d;

  // Bar colour is looked up from the requested column and lands with lcd_de.
  always_comb begin
    bar_idx = (pixel_xpos_q - CNT_W'(1)) / CNT_W'(BAR_W);
    bar_d   = bar_colour((bar_idx > CNT_W'(NUM_BARS - 1)) ? 3'd7 : bar_idx[2:0]);
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      bar_q <= '0;
    end else begin
      bar_q <= bar_d;
    end
  end

  assign rgb_src = test_mode ? bar_q : pixel_data;
`else
  assign rgb_src = pixel_data;
`endif

  always_comb begin
    lcd_rgb = '0;
    if (lcd_de_q) begin
      lcd_rgb = rgb_src;
    end
  end

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Scoreboard bench for lcd_timing_driver using a shrunken timing so many whole
// frames, line/frame wraps and random resets fit in a short run.
module tb_lcd_timing_driver;

  localparam int HS = 4, HB = 3, HD = 16, HF = 2;
  localparam int VS = 2, VB = 2, VD = 5,  VF = 1;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int N_CYC = 4000;

  typedef struct {
    logic        hs, vs, de, req, fs;
    logic [10:0] x, y;
    logic [23:0] rgb;
  } exp_t;

  logic        lcd_pclk = 1'b0;
  logic        rst;
  logic [23:0] pixel_data;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        data_req, lcd_hs, lcd_vs, lcd_de, frame_start;
  logic [23:0] lcd_rgb;

  always #5 lcd_pclk = ~lcd_pclk;

  lcd_timing_driver #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
  ) dut (
    .lcd_pclk(lcd_pclk),
    .rst(rst),
`ifdef LCD_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos),
    .pixel_ypos(pixel_ypos),
    .h_disp(h_disp),
    .v_disp(v_disp),
    .data_req(data_req),
    .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs),
    .lcd_de(lcd_de),
    .lcd_rgb(lcd_rgb),
    .frame_start(frame_start)
  );

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mon_cyc = 0;
  int   fs_seen = 0;
  int   fs_expected = 0;
  bit   drv_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, mon_cyc, act, req);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.req = 1'b0; e.fs = 1'b0;
    e.x = '0; e.y = '0; e.rgb = '0;
    return e;
  endfunction

  // Output cycle t after reset release shows the timing of raster position t.
  function automatic exp_t model(input int t, input logic [1:0] r);
    exp_t e;
    int   h, v;
    bit   vwin;
    h    = t % HT;
    v    = (t / HT) % VT;
    vwin = (v >= VS + VB) && (v < VS + VB + VD);
    e.hs  = !(h < HS);
    e.vs  = !(v < VS);
    e.req = vwin && (h >= HS + HB - 1) && (h < HS + HB - 1 + HD);
    e.de  = vwin && (h >= HS + HB) && (h < HS + HB + HD);
    e.fs  = (h == 0) && (v == 0);
    e.x   = e.req ? 11'(h - (HS + HB) + 2) : 11'd0;
    e.y   = e.req ? 11'(v - (VS + VB) + 1) : 11'd0;
    e.rgb = e.de ? {r, 11'(h - (HS + HB) + 1), 11'(v - (VS + VB) + 1)} : 24'd0;
    return e;
  endfunction

  // Stimulus: an echo consumer returns the requested coordinates one cycle
  // later with two random tag bits, while reset is pulsed directed and at random.
  initial begin
    logic [21:0] cap;
    logic [1:0]  r;
    exp_t        e;
    int          t;
    bit          did_mid;
    rst = 1'b1;
    pixel_data = '0;
    t = 0;
    did_mid = 1'b0;
    repeat (2) @(posedge lcd_pclk);
    for (int n = 0; n < N_CYC; n++) begin
      @(negedge lcd_pclk);
      cap = {pixel_xpos, pixel_ypos};
      @(posedge lcd_pclk);
      #1;
      r = 2'($urandom);
      pixel_data = {r, cap};
      if (rst) begin
        e = reset_exp();
        t = 0;
      end else begin
        e = model(t, r);
        t++;
      end
      if (e.fs) fs_expected++;
      sb_q.push_back(e);
      if (n < 3) begin
        rst = 1'b1;
      end else if (!did_mid && n > 600 && t == 5 * HT + 12) begin
        rst = 1'b1;
        did_mid = 1'b1;
      end else if (n > 1200) begin
        rst = ($urandom_range(0, 299) == 0);
      end else begin
        rst = 1'b0;
      end
    end
    drv_done = 1'b1;
  end

  // Monitor: every clock cycle is an output cycle; compare it against the
  // oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge lcd_pclk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        mon_cyc++;
        if (frame_start === 1'b1) fs_seen++;
        check("lcd_hs",      32'(lcd_hs),      32'(e.hs));
        check("lcd_vs",      32'(lcd_vs),      32'(e.vs));
        check("data_req",    32'(data_req),    32'(e.req));
        check("lcd_de",      32'(lcd_de),      32'(e.de));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("pixel_xpos",  32'(pixel_xpos),  32'(e.x));
        check("pixel_ypos",  32'(pixel_ypos),  32'(e.y));
        check("lcd_rgb",     32'(lcd_rgb),     32'(e.rgb));
        if (mon_cyc == 1) begin
          check("h_disp", 32'(h_disp), 32'(HD));
          check("v_disp", 32'(v_disp), 32'(VD));
        end
      end
    end
  end

  initial begin
    wait (drv_done);
    repeat (3) @(negedge lcd_pclk);
    check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    check("frame_start_count", 32'(fs_seen), 32'(fs_expected));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
